pipe_run_ctrl: RTL and testbench

- Run/halt/single-step sequencer for the five-stage pipelined CPU.
- Produces one freeze enable, cpu_en, which gates every pipeline state element together:
  - PC register, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers;
  - register-file and data-RAM write enables.
- Because the whole machine freezes as one, no drain is needed.
- Also provides a PC breakpoint comparator and an enabled-cycle counter for board debug and simulation.

---
 rtl/pipe_dbg_pkg.sv | 24 ++
 rtl/pipe_run_ctrl_if.sv | 36 +++
 rtl/pipe_run_ctrl_edge_det.sv | 33 +++
 rtl/pipe_run_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_run_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_dbg_pkg
// Purpose  : Shared state encodings and widths for the pipeline run/halt/step
//            debug controller and its bus interface.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_dbg_pkg;

  // Width of the IF-stage program counter and of the breakpoint address.
  localparam int PC_W = 32;

  // Width of the enabled-cycle counter.
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } run_state_e;

endpackage : pipe_dbg_pkg
`default_nettype wire

// File: rtl/pipe_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_run_ctrl_if
// Purpose  : Bundles the debug requests, breakpoint setup, current PC and the
//            controller status outputs of pipe_run_ctrl.
// Ports    : master - debug host side (drives requests, bp setup and pc)
//            slave  - controller side (drives cpu_en, state, bp_hit,
//                     cycle_cnt)
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_run_ctrl_if;
  import pipe_dbg_pkg::*;

  logic             run_req;
  logic             halt_req;
  logic             step_req;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             cpu_en;
  logic [1:0]       state;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output run_req, halt_req, step_req, bp_en, bp_addr, pc,
    input  cpu_en, state, bp_hit, cycle_cnt
  );

  modport slave (
    input  run_req, halt_req, step_req, bp_en, bp_addr, pc,
    output cpu_en, state, bp_hit, cycle_cnt
  );

endinterface : pipe_run_ctrl_if
`default_nettype wire

// File: rtl/pipe_run_ctrl_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : edge_det
// Purpose  : One-bit rising-edge detector. The request is registered and the
//            output is high for the single cycle in which the request is high
//            and its registered copy is still low, so a held level fires once.
// Ports    : clock  - rising-edge clock
//            resetn - asynchronous active-low reset
//            req_i  - level request
//            edge_o - rising-edge strobe (combinational from req_i)
// Revision : 1.0 - initial release
// ============================================================================
module edge_det (
  input  logic clock,
  input  logic resetn,
  input  logic req_i,
  output logic edge_o
);

  logic req_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_i;
    end
  end

  assign edge_o = req_i & ~req_q;

endmodule : edge_det
`default_nettype wire

// File: rtl/pipe_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_run_ctrl
// Purpose  : Run/halt/single-step sequencer for the five-stage pipelined CPU.
//            Produces one pipeline-wide freeze enable (cpu_en), a PC
//            breakpoint trap and a count of enabled cycles.
// Ports    : clock   - rising-edge clock
//            resetn  - asynchronous active-low reset
//            bus     - pipe_run_ctrl_if.slave: run/halt/step requests,
//                      bp_en/bp_addr, pc in; cpu_en, state, bp_hit,
//                      cycle_cnt out
// Params   : STEP_LEN     - enabled cycles granted per step request (1..255)
//            RUN_ON_RESET - 1: leave reset in RUN, 0: leave reset in HALT
// Revision : 1.0 - initial release
// ============================================================================
module pipe_run_ctrl
  import pipe_dbg_pkg::*;
#(
  parameter int unsigned STEP_LEN     = 1,
  parameter bit          RUN_ON_RESET = 1'b0
) (
  input  logic           clock,
  input  logic           resetn,
  pipe_run_ctrl_if.slave bus
);

  if ((STEP_LEN < 1) || (STEP_LEN > 255)) begin : g_bad_step_len
    $error("pipe_run_ctrl: STEP_LEN must be in 1..255, got %0d", STEP_LEN);
  end

  localparam logic [7:0]  STEP_INIT   = 8'(STEP_LEN);
  localparam run_state_e  RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;

  run_state_e       state_q,     state_d;
  logic [7:0]       step_cnt_q,  step_cnt_d;
  logic             skip_q,      skip_d;
  logic             bp_hit_q,    bp_hit_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  logic run_edge;
  logic halt_edge;
  logic step_edge;
  logic bp_match;
  logic bp_trap;
  logic cpu_en;
  logic resume;

  edge_det u_run_edge (
    .clock  (clock),
    .resetn (resetn),
    .req_i  (bus.run_req),
    .edge_o (run_edge)
  );

  edge_det u_halt_edge (
    .clock  (clock),
    .resetn (resetn),
    .req_i  (bus.halt_req),
    .edge_o (halt_edge)
  );

  edge_det u_step_edge (
    .clock  (clock),
    .resetn (resetn),
    .req_i  (bus.step_req),
    .edge_o (step_edge)
  );

  // A match only traps once the first instruction after a resume has been
  // let through; otherwise resuming at bp_addr would re-trap forever.
  assign bp_match = bus.bp_en & (bus.pc == bus.bp_addr);
  assign bp_trap  = bp_match & ~skip_q;

  always_comb begin
    cpu_en = 1'b0;
    unique case (state_q)
      ST_RUN:  cpu_en = ~bp_trap;
      ST_STEP: cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    bp_hit_d   = 1'b0;
    resume     = 1'b0;

    unique case (state_q)
      ST_HALT, ST_BRK: begin
        // Priority halt > step > run when edges coincide.
        if (halt_edge) begin
          state_d = ST_HALT;
        end else if (step_edge) begin
          state_d    = ST_STEP;
          step_cnt_d = STEP_INIT;
          resume     = 1'b1;
        end else if (run_edge) begin
          state_d = ST_RUN;
          resume  = 1'b1;
        end
      end

      ST_RUN: begin
        // A halt edge still lets the current cycle advance (cpu_en stays
        // high unless a trap suppresses it); only then does the machine stop.
        if (halt_edge) begin
          state_d = ST_HALT;
        end else if (bp_trap) begin
          state_d  = ST_BRK;
          bp_hit_d = 1'b1;
        end
      end

      ST_STEP: begin
        // Breakpoints and further step edges are ignored while stepping.
        if (halt_edge) begin
          state_d    = ST_HALT;
          step_cnt_d = 8'd0;
        end else begin
          step_cnt_d = step_cnt_q - 8'd1;
          if (step_cnt_q == 8'd1) begin
            state_d = ST_HALT;
          end
        end
      end

      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    skip_d = skip_q;
    if (resume) begin
      skip_d = 1'b1;
    end else if (cpu_en) begin
      skip_d = 1'b0;
    end
  end

  assign cycle_cnt_d = cpu_en ? (cycle_cnt_q + 32'd1) : cycle_cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RESET_STATE;
      step_cnt_q  <= 8'd0;
      skip_q      <= 1'b0;
      bp_hit_q    <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      skip_q      <= skip_d;
      bp_hit_q    <= bp_hit_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign bus.cpu_en    = cpu_en;
  assign bus.state     = state_q;
  assign bus.bp_hit    = bp_hit_q;
  assign bus.cycle_cnt = cycle_cnt_q;

endmodule : pipe_run_ctrl
`default_nettype wire

// File: tb/tb_pipe_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_run_ctrl
// Purpose  : Self-checking bench for pipe_run_ctrl (STEP_LEN = 3,
//            RUN_ON_RESET = 0). Each cycle's expected cpu_en/state/bp_hit/
//            cycle_cnt is queued as stimulus is driven and compared once the
//            outputs settle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_run_ctrl;
  import pipe_dbg_pkg::*;

  typedef struct packed {
    logic        r;
    logic        h;
    logic        s;
    logic [31:0] pc;
    logic        en;
    logic [1:0]  st;
    logic        hit;
  } vec_t;

  typedef struct packed {
    logic        en;
    logic [1:0]  st;
    logic        hit;
    logic [31:0] cnt;
  } exp_t;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] exp_cnt = 32'd0;
  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;

  pipe_run_ctrl_if bus ();

  pipe_run_ctrl #(
    .STEP_LEN     (3),
    .RUN_ON_RESET (1'b0)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t V(input logic r, input logic h, input logic s,
                             input logic [31:0] pc, input logic en,
                             input logic [1:0] st, input logic hit);
    return '{r, h, s, pc, en, st, hit};
  endfunction

  // Drives one cycle of stimulus and queues what that cycle must show.
  task automatic apply(input vec_t v);
    @(negedge clock);
    bus.run_req  = v.r;
    bus.halt_req = v.h;
    bus.step_req = v.s;
    bus.pc       = v.pc;
    sb.push_back('{v.en, v.st, v.hit, exp_cnt});
    if (v.en) exp_cnt = exp_cnt + 32'd1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    bus.run_req = 1'b0; bus.halt_req = 1'b0; bus.step_req = 1'b0;
    @(negedge clock);
    resetn  = 1'b1;
    exp_cnt = 32'd0;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      sb.push_back('{1'b0, ST_HALT, 1'b0, 32'd0});
      e = sb.pop_front();
      vectors++;
      if ({bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt} !== e) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got en=%b st=%b hit=%b cnt=%h, want en=%b st=%b hit=%b cnt=%h",
                 i, bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt, e.en, e.st, e.hit, e.cnt);
      end
    end
    @(negedge clock);
    resetn  = 1'b1;
    exp_cnt = 32'd0;
  endtask

  task automatic test_run();
    vec_t t[$];
    exp_t e;
    t.push_back(V(1,0,0,32'h0,0,ST_HALT,0));
    for (int k = 0; k < 4; k++) t.push_back(V(0,0,0,32'h0,1,ST_RUN,0));
    t.push_back(V(0,1,0,32'h0,1,ST_RUN,0));
    t.push_back(V(0,0,0,32'h0,0,ST_HALT,0));
    foreach (t[i]) begin
      apply(t[i]);
      e = sb.pop_front();
      vectors++;
      if ({bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt} !== e) begin
        miscompares++;
        $display("FAIL run[%0d]: got en=%b st=%b hit=%b cnt=%h, want en=%b st=%b hit=%b cnt=%h",
                 i, bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt, e.en, e.st, e.hit, e.cnt);
      end
    end
  endtask

  task automatic test_step();
    vec_t t[$];
    exp_t e;
    t.push_back(V(0,0,1,32'h0,0,ST_HALT,0));
    for (int k = 0; k < 3; k++) t.push_back(V(0,0,0,32'h0,1,ST_STEP,0));
    t.push_back(V(0,0,0,32'h0,0,ST_HALT,0));
    // step_req held high for five cycles: acted on once only
    t.push_back(V(0,0,1,32'h0,0,ST_HALT,0));
    for (int k = 0; k < 3; k++) t.push_back(V(0,0,1,32'h0,1,ST_STEP,0));
    t.push_back(V(0,0,1,32'h0,0,ST_HALT,0));
    t.push_back(V(0,0,0,32'h0,0,ST_HALT,0));
    t.push_back(V(0,0,0,32'h0,0,ST_HALT,0));
    foreach (t[i]) begin
      apply(t[i]);
      e = sb.pop_front();
      vectors++;
      if ({bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt} !== e) begin
        miscompares++;
        $display("FAIL step[%0d]: got en=%b st=%b hit=%b cnt=%h, want en=%b st=%b hit=%b cnt=%h",
                 i, bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt, e.en, e.st, e.hit, e.cnt);
      end
    end
  endtask

  task automatic test_breakpoint();
    vec_t t[$];
    exp_t e;
    do_reset();
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h0000_0010;
    t.push_back(V(1,0,0,32'h00,0,ST_HALT,0));
    t.push_back(V(0,0,0,32'h00,1,ST_RUN,0));
    t.push_back(V(0,0,0,32'h04,1,ST_RUN,0));
    t.push_back(V(0,0,0,32'h08,1,ST_RUN,0));
    t.push_back(V(0,0,0,32'h0C,1,ST_RUN,0));
    t.push_back(V(0,0,0,32'h10,0,ST_RUN,0));
    t.push_back(V(0,0,0,32'h10,0,ST_BRK,1));
    t.push_back(V(0,0,0,32'h10,0,ST_BRK,0));
    t.push_back(V(1,0,0,32'h10,0,ST_BRK,0));
    t.push_back(V(0,0,0,32'h10,1,ST_RUN,0));
    t.push_back(V(0,0,0,32'h14,1,ST_RUN,0));
    t.push_back(V(0,1,0,32'h18,1,ST_RUN,0));
    t.push_back(V(0,0,0,32'h18,0,ST_HALT,0));
    foreach (t[i]) begin
      apply(t[i]);
      e = sb.pop_front();
      vectors++;
      if ({bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt} !== e) begin
        miscompares++;
        $display("FAIL breakpoint[%0d]: got en=%b st=%b hit=%b cnt=%h, want en=%b st=%b hit=%b cnt=%h",
                 i, bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt, e.en, e.st, e.hit, e.cnt);
      end
    end
    bus.bp_en = 1'b0;
  endtask

  task automatic test_coincident();
    vec_t t[$];
    exp_t e;
    t.push_back(V(1,0,0,32'h0,0,ST_HALT,0));
    t.push_back(V(0,0,0,32'h0,1,ST_RUN,0));
    t.push_back(V(0,1,1,32'h0,1,ST_RUN,0));   // halt beats step
    t.push_back(V(0,0,0,32'h0,0,ST_HALT,0));
    t.push_back(V(0,0,0,32'h0,0,ST_HALT,0));
    t.push_back(V(1,0,1,32'h0,0,ST_HALT,0));  // step beats run
    for (int k = 0; k < 3; k++) t.push_back(V(0,0,0,32'h0,1,ST_STEP,0));
    t.push_back(V(0,0,0,32'h0,0,ST_HALT,0));
    foreach (t[i]) begin
      apply(t[i]);
      e = sb.pop_front();
      vectors++;
      if ({bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt} !== e) begin
        miscompares++;
        $display("FAIL coincident[%0d]: got en=%b st=%b hit=%b cnt=%h, want en=%b st=%b hit=%b cnt=%h",
                 i, bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt, e.en, e.st, e.hit, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_step();
    vec_t t[$];
    exp_t e;
    t.push_back(V(0,0,1,32'h0,0,ST_HALT,0));
    t.push_back(V(0,0,0,32'h0,1,ST_STEP,0));
    foreach (t[i]) begin
      apply(t[i]);
      e = sb.pop_front();
      vectors++;
      if ({bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt} !== e) begin
        miscompares++;
        $display("FAIL mid_step_pre[%0d]: got en=%b st=%b hit=%b cnt=%h, want en=%b st=%b hit=%b cnt=%h",
                 i, bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt, e.en, e.st, e.hit, e.cnt);
      end
    end
    // Assert reset between clock edges; outputs must clear without a clock.
    @(negedge clock);
    resetn = 1'b0;
    #1;
    sb.push_back('{1'b0, ST_HALT, 1'b0, 32'd0});
    e = sb.pop_front();
    vectors++;
    if ({bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt} !== e) begin
      miscompares++;
      $display("FAIL async_reset: got en=%b st=%b hit=%b cnt=%h, want en=%b st=%b hit=%b cnt=%h",
               bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt, e.en, e.st, e.hit, e.cnt);
    end
    exp_cnt = 32'd0;
    @(negedge clock);
    resetn = 1'b1;
    t.delete();
    t.push_back(V(0,0,1,32'h0,0,ST_HALT,0));
    for (int k = 0; k < 3; k++) t.push_back(V(0,0,0,32'h0,1,ST_STEP,0));
    t.push_back(V(0,0,0,32'h0,0,ST_HALT,0));
    foreach (t[i]) begin
      apply(t[i]);
      e = sb.pop_front();
      vectors++;
      if ({bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt} !== e) begin
        miscompares++;
        $display("FAIL mid_step_post[%0d]: got en=%b st=%b hit=%b cnt=%h, want en=%b st=%b hit=%b cnt=%h",
                 i, bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt, e.en, e.st, e.hit, e.cnt);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t t[$];
    exp_t e;
    @(negedge clock);
    force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    t.push_back(V(1,0,0,32'h0,0,ST_HALT,0));
    t.push_back(V(0,0,0,32'h0,1,ST_RUN,0));
    t.push_back(V(0,0,0,32'h0,1,ST_RUN,0));
    t.push_back(V(0,1,0,32'h0,1,ST_RUN,0));
    t.push_back(V(0,0,0,32'h0,0,ST_HALT,0));  // count must read 0x0000_0001
    foreach (t[i]) begin
      apply(t[i]);
      e = sb.pop_front();
      vectors++;
      if ({bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt} !== e) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got en=%b st=%b hit=%b cnt=%h, want en=%b st=%b hit=%b cnt=%h",
                 i, bus.cpu_en, bus.state, bus.bp_hit, bus.cycle_cnt, e.en, e.st, e.hit, e.cnt);
      end
    end
  endtask

  initial begin
    bus.run_req  = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 32'h0;
    bus.pc       = 32'h0;
    resetn       = 1'b0;
    test_reset();
    test_run();
    test_step();
    test_breakpoint();
    test_coincident();
    test_reset_mid_step();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pipe_run_ctrl
`default_nettype wire
